// File: rtl/mp85_pkg.sv
// mp85_pkg: shared types and constants for the mp85 8085-subset core.
// FSM states, register slot codes, flag bit positions, opcode patterns and
// an instruction-length decoder used by the fetch sequencer.
package mp85_pkg;

    typedef enum logic [2:0] {
        ST_FETCH = 3'd0,
        ST_OPER1 = 3'd1,
        ST_OPER2 = 3'd2,
        ST_EXEC  = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    // 8085 register slot codes; M is an ordinary register here.
    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_M = 3'd6,
        REG_A = 3'd7
    } reg_idx_e;

    // Bit positions inside the 3-bit flag register.
    localparam int FLAG_CY = 0;
    localparam int FLAG_Z  = 1;
    localparam int FLAG_S  = 2;

    // Exact opcodes.
    localparam logic [7:0] OP_HLT   = 8'h76;
    localparam logic [7:0] OP_JMP   = 8'hC3;

    // Group masks and patterns: (opcode & MASK) == PAT.
    localparam logic [7:0] MASK_MOV = 8'hC0;
    localparam logic [7:0] PAT_MOV  = 8'h40;
    localparam logic [7:0] MASK_MVI = 8'hC7;
    localparam logic [7:0] PAT_MVI  = 8'h06;
    localparam logic [7:0] PAT_INR  = 8'h04;
    localparam logic [7:0] PAT_DCR  = 8'h05;
    localparam logic [7:0] MASK_ALU = 8'hF8;
    localparam logic [7:0] PAT_ADD  = 8'h80;
    localparam logic [7:0] PAT_SUB  = 8'h90;
    localparam logic [7:0] PAT_ANA  = 8'hA0;
    localparam logic [7:0] PAT_XRA  = 8'hA8;
    localparam logic [7:0] PAT_ORA  = 8'hB0;

    // Instruction length in bytes: JMP is 3, MVI is 2, everything else 1.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        if (op == OP_JMP) begin
            len = 2'd3;
        end else if ((op & MASK_MVI) == PAT_MVI) begin
            len = 2'd2;
        end else begin
            len = 2'd1;
        end
        return len;
    endfunction

endpackage

// File: rtl/mp85_regfile.sv
// mp85_regfile: 8 x 8-bit register file, two combinational read ports and
// one synchronous write port. All slots clear on synchronous reset.
// debug_regs_flat packs {A, M, L, H, E, D, C, B} with B in the low byte.
module mp85_regfile
    import mp85_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [7:0]  i_wdata,
    input  logic [2:0]  i_raddr0,
    output logic [7:0]  o_rdata0,
    input  logic [2:0]  i_raddr1,
    output logic [7:0]  o_rdata1,
    output logic [63:0] debug_regs_flat
);

    logic [7:0] r_regs [8];

    // Register storage: reset clears every slot, otherwise single write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 8'h00;
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Combinational read ports and the flattened debug view.
    always_comb begin
        o_rdata0        = r_regs[i_raddr0];
        o_rdata1        = r_regs[i_raddr1];
        debug_regs_flat = {r_regs[7], r_regs[6], r_regs[5], r_regs[4],
                           r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
    end

endmodule

// File: rtl/mp85.sv
// mp85: single-clock 8085-subset core with internal program ROM.
// Sequencer FETCH -> OPER1 -> OPER2 -> EXEC, with HALT as a sink until reset.
// Optional macro MP85_LOGIC_OPS_EN enables ANA/XRA/ORA; without it those
// opcodes behave as 1-byte NOPs.
// ROM_IMAGE selects the built-in program: 0 = default demo, 1 = flag/wrap demo.
module mp85
    import mp85_pkg::*;
#(
    parameter int          ROM_DEPTH = 256,
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          ROM_IMAGE = 0
) (
    input logic clk,
    input logic rst
);

    localparam logic [15:0] ROM_LIMIT = 16'(ROM_DEPTH);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [7:0]  r_ir;
    logic [7:0]  w_ir_nxt;
    logic [7:0]  r_lo;
    logic [7:0]  w_lo_nxt;
    logic [7:0]  r_hi;
    logic [7:0]  w_hi_nxt;
    logic [2:0]  r_flags;
    logic [2:0]  w_flags_nxt;

    logic        w_we;
    logic [2:0]  w_waddr;
    logic [7:0]  w_wdata;
    logic [2:0]  w_rd1_addr;
    logic [7:0]  w_rd0;
    logic [7:0]  w_rd1;
    logic [8:0]  w_res;
    logic [15:0] w_rom_addr;
    logic [7:0]  w_rom_data;

    // Build a flag word for an arithmetic/logic result with the given carry.
    function automatic logic [2:0] arith_flags(input logic [7:0] res, input logic cy);
        logic [2:0] f;
        f          = 3'b000;
        f[FLAG_Z]  = (res == 8'h00);
        f[FLAG_S]  = res[7];
        f[FLAG_CY] = cy;
        return f;
    endfunction

    // Program ROM contents; unlisted addresses read as 00 (NOP).
    function automatic logic [7:0] rom_byte(input logic [15:0] addr);
        logic [7:0] d;
        d = 8'h00;
        if (ROM_IMAGE == 1) begin
            case (addr)
                16'h0000: d = 8'h06;  // MVI B,01
                16'h0001: d = 8'h01;
                16'h0002: d = 8'h3E;  // MVI A,00
                16'h0003: d = 8'h00;
                16'h0004: d = 8'h90;  // SUB B
                16'h0005: d = 8'h3C;  // INR A
                16'h0006: d = 8'h3E;  // MVI A,0F
                16'h0007: d = 8'h0F;
                16'h0008: d = 8'h06;  // MVI B,3C
                16'h0009: d = 8'h3C;
                16'h000A: d = 8'hB0;  // ORA B
                16'h000B: d = 8'hAF;  // XRA A
                16'h000C: d = 8'h76;  // HLT
                default:  d = 8'h00;
            endcase
        end else begin
            case (addr)
                16'h0000: d = 8'h3E;  // MVI A,05
                16'h0001: d = 8'h05;
                16'h0002: d = 8'h06;  // MVI B,03
                16'h0003: d = 8'h03;
                16'h0004: d = 8'h80;  // ADD B
                16'h0005: d = 8'h4F;  // MOV C,A
                16'h0006: d = 8'h90;  // SUB B
                16'h0007: d = 8'h05;  // DCR B
                16'h0008: d = 8'hC3;  // JMP 000B
                16'h0009: d = 8'h0B;
                16'h000A: d = 8'h00;
                16'h000B: d = 8'h76;  // HLT
                default:  d = 8'h00;
            endcase
        end
        return d;
    endfunction

    // ROM lookup; PC is folded into the ROM by modulo.
    always_comb begin
        w_rom_addr = r_pc % ROM_LIMIT;
        w_rom_data = rom_byte(w_rom_addr);
    end

    // Second read port serves A for ALU-group ops, the target for INR/DCR.
    always_comb begin
        if (r_ir[7:6] == 2'b10) begin
            w_rd1_addr = REG_A;
        end else begin
            w_rd1_addr = r_ir[5:3];
        end
    end

    mp85_regfile regfile (
        .clk             (clk),
        .rst             (rst),
        .i_we            (w_we),
        .i_waddr         (w_waddr),
        .i_wdata         (w_wdata),
        .i_raddr0        (r_ir[2:0]),
        .o_rdata0        (w_rd0),
        .i_raddr1        (w_rd1_addr),
        .o_rdata1        (w_rd1),
        .debug_regs_flat ()
    );

    // Next-state, operand capture and execute datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_lo_nxt    = r_lo;
        w_hi_nxt    = r_hi;
        w_flags_nxt = r_flags;
        w_we        = 1'b0;
        w_waddr     = r_ir[5:3];
        w_wdata     = 8'h00;
        w_res       = 9'h000;
        case (r_state)
            ST_FETCH: begin
                w_ir_nxt = w_rom_data;
                w_pc_nxt = r_pc + 16'h0001;
                if (op_len(w_rom_data) != 2'd1) begin
                    w_state_nxt = ST_OPER1;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_OPER1: begin
                w_lo_nxt = w_rom_data;
                w_pc_nxt = r_pc + 16'h0001;
                if (op_len(r_ir) == 2'd3) begin
                    w_state_nxt = ST_OPER2;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_OPER2: begin
                w_hi_nxt    = w_rom_data;
                w_pc_nxt    = r_pc + 16'h0001;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                w_state_nxt = ST_FETCH;
                // HLT shares the MOV encoding space, so it is decoded first.
                if (r_ir == OP_HLT) begin
                    w_state_nxt = ST_HALT;
                end else if ((r_ir & MASK_MOV) == PAT_MOV) begin
                    w_we    = 1'b1;
                    w_wdata = w_rd0;
                end else if ((r_ir & MASK_MVI) == PAT_MVI) begin
                    w_we    = 1'b1;
                    w_wdata = r_lo;
                end else if ((r_ir & MASK_MVI) == PAT_INR) begin
                    w_res       = {1'b0, w_rd1} + 9'h001;
                    w_we        = 1'b1;
                    w_wdata     = w_res[7:0];
                    w_flags_nxt = arith_flags(w_res[7:0], r_flags[FLAG_CY]);
                end else if ((r_ir & MASK_MVI) == PAT_DCR) begin
                    w_res       = {1'b0, w_rd1} - 9'h001;
                    w_we        = 1'b1;
                    w_wdata     = w_res[7:0];
                    w_flags_nxt = arith_flags(w_res[7:0], r_flags[FLAG_CY]);
                end else if (r_ir == OP_JMP) begin
                    w_pc_nxt = {r_hi, r_lo};
                end else if ((r_ir & MASK_ALU) == PAT_ADD) begin
                    w_res       = {1'b0, w_rd1} + {1'b0, w_rd0};
                    w_we        = 1'b1;
                    w_waddr     = REG_A;
                    w_wdata     = w_res[7:0];
                    w_flags_nxt = arith_flags(w_res[7:0], w_res[8]);
                end else if ((r_ir & MASK_ALU) == PAT_SUB) begin
                    // Bit 8 of the 9-bit difference is the borrow.
                    w_res       = {1'b0, w_rd1} - {1'b0, w_rd0};
                    w_we        = 1'b1;
                    w_waddr     = REG_A;
                    w_wdata     = w_res[7:0];
                    w_flags_nxt = arith_flags(w_res[7:0], w_res[8]);
`ifdef MP85_LOGIC_OPS_EN
                end else if ((r_ir & MASK_ALU) == PAT_ANA) begin
                    w_we        = 1'b1;
                    w_waddr     = REG_A;
                    w_wdata     = w_rd1 & w_rd0;
                    w_flags_nxt = arith_flags(w_rd1 & w_rd0, 1'b0);
                end else if ((r_ir & MASK_ALU) == PAT_XRA) begin
                    w_we        = 1'b1;
                    w_waddr     = REG_A;
                    w_wdata     = w_rd1 ^ w_rd0;
                    w_flags_nxt = arith_flags(w_rd1 ^ w_rd0, 1'b0);
                end else if ((r_ir & MASK_ALU) == PAT_ORA) begin
                    w_we        = 1'b1;
                    w_waddr     = REG_A;
                    w_wdata     = w_rd1 | w_rd0;
                    w_flags_nxt = arith_flags(w_rd1 | w_rd0, 1'b0);
`endif
                end else begin
                    // NOP and every unlisted opcode: nothing changes.
                    w_we = 1'b0;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Sequencer state; reset discards any partially executed instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_lo    <= 8'h00;
            r_hi    <= 8'h00;
            r_flags <= 3'b000;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_lo    <= w_lo_nxt;
            r_hi    <= w_hi_nxt;
            r_flags <= w_flags_nxt;
        end
    end

endmodule

// File: tb/tb_mp85.sv
// tb_mp85: directed bench for mp85. u_dut runs the default ROM image,
// u_dut2 runs the flag/wrap image. Expected values are hand-computed
// from the instruction timings (1-byte = 2 clk, MVI = 3, JMP = 4).
module tb_mp85;
    import mp85_pkg::*;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    mp85 u_dut (
        .clk (clk),
        .rst (rst)
    );

    mp85 #(.ROM_IMAGE(1)) u_dut2 (
        .clk (clk),
        .rst (rst2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held for two clocks.
        rst = 1'b1;
        tick(2);
        check_val("rst_regs", u_dut.regfile.debug_regs_flat, 64'h0);
        check_val("rst_pc",   {48'h0, u_dut.r_pc}, 64'h0);
        check_val("rst_flag", {61'h0, u_dut.r_flags}, 64'h0);
        rst = 1'b0;

        tick(3);
        check_val("mvi_a", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0000);

        // Reset in the middle of MVI B (after FETCH and OPER1).
        tick(2);
        check_val("mid_no_wr", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0000);
        rst = 1'b1;
        tick(1);
        check_val("mid_rst_regs", u_dut.regfile.debug_regs_flat, 64'h0);
        check_val("mid_rst_pc",   {48'h0, u_dut.r_pc}, 64'h0);
        rst = 1'b0;

        // Program restarts from 0000.
        tick(3);
        check_val("re_mvi_a", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0000);
        tick(3);
        check_val("mvi_b", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0003);
        tick(2);
        check_val("add_b", u_dut.regfile.debug_regs_flat, 64'h0800_0000_0000_0003);
        tick(2);
        check_val("mov_ca", u_dut.regfile.debug_regs_flat, 64'h0800_0000_0000_0803);
        tick(2);
        check_val("sub_b", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0803);
        check_val("sub_cy", {63'h0, u_dut.r_flags[FLAG_CY]}, 64'h0);
        tick(2);
        check_val("dcr_b", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0802);
        check_val("untouched", {32'h0, u_dut.regfile.debug_regs_flat[55:24]}, 64'h0);
        tick(4);
        check_val("jmp_pc", {48'h0, u_dut.r_pc}, 64'h0000_0000_0000_000B);
        tick(2);
        check_val("hlt_pc", {48'h0, u_dut.r_pc}, 64'h0000_0000_0000_000C);
        tick(1);
        tick(50);
        check_val("halt_regs", u_dut.regfile.debug_regs_flat, 64'h0500_0000_0000_0802);
        check_val("halt_pc",   {48'h0, u_dut.r_pc}, 64'h0000_0000_0000_000C);
        check_val("halt_flag", {61'h0, u_dut.r_flags}, 64'h0);

        // Flag/wrap program on the second instance.
        rst2 = 1'b1;
        tick(1);
        rst2 = 1'b0;
        tick(6);
        check_val("w_init", u_dut2.regfile.debug_regs_flat, 64'h0000_0000_0000_0001);
        tick(2);
        check_val("w_sub_a",  u_dut2.regfile.debug_regs_flat, 64'hFF00_0000_0000_0001);
        check_val("w_sub_s",  {63'h0, u_dut2.r_flags[FLAG_S]},  64'h1);
        check_val("w_sub_cy", {63'h0, u_dut2.r_flags[FLAG_CY]}, 64'h1);
        check_val("w_sub_z",  {63'h0, u_dut2.r_flags[FLAG_Z]},  64'h0);
        tick(2);
        check_val("w_inr_a",  u_dut2.regfile.debug_regs_flat, 64'h0000_0000_0000_0001);
        check_val("w_inr_z",  {63'h0, u_dut2.r_flags[FLAG_Z]},  64'h1);
        check_val("w_inr_s",  {63'h0, u_dut2.r_flags[FLAG_S]},  64'h0);
        check_val("w_inr_cy", {63'h0, u_dut2.r_flags[FLAG_CY]}, 64'h1);
        tick(6);
        check_val("l_init", u_dut2.regfile.debug_regs_flat, 64'h0F00_0000_0000_003C);
        tick(2);
`ifdef MP85_LOGIC_OPS_EN
        check_val("l_ora", u_dut2.regfile.debug_regs_flat, 64'h3F00_0000_0000_003C);
`else
        check_val("l_ora", u_dut2.regfile.debug_regs_flat, 64'h0F00_0000_0000_003C);
`endif
        tick(2);
`ifdef MP85_LOGIC_OPS_EN
        check_val("l_xra",    u_dut2.regfile.debug_regs_flat, 64'h0000_0000_0000_003C);
        check_val("l_xra_z",  {63'h0, u_dut2.r_flags[FLAG_Z]},  64'h1);
        check_val("l_xra_cy", {63'h0, u_dut2.r_flags[FLAG_CY]}, 64'h0);
`else
        check_val("l_xra",    u_dut2.regfile.debug_regs_flat, 64'h0F00_0000_0000_003C);
        check_val("l_xra_z",  {63'h0, u_dut2.r_flags[FLAG_Z]},  64'h1);
        check_val("l_xra_cy", {63'h0, u_dut2.r_flags[FLAG_CY]}, 64'h1);
`endif
        tick(2);
        check_val("l_hlt_pc", {48'h0, u_dut2.r_pc}, 64'h0000_0000_0000_000D);
        tick(5);
        check_val("l_hlt_pc2", {48'h0, u_dut2.r_pc}, 64'h0000_0000_0000_000D);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
